elastic_pipe_reg: RTL



---
 rtl/elastic_pipe_reg_pkg.sv | 10 +
 rtl/elastic_stage.sv | 52 +++++
 rtl/elastic_pipe_reg.sv | 104 ++++++++++
 3 files changed

// File: rtl/elastic_pipe_reg_pkg.sv
// Shared helpers for the elastic pipeline register.
// Provides the occupancy counter width calculation used by the top-level port list.
package elastic_pipe_reg_pkg;

    // Width needed to count 0..depth valid stages.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/elastic_stage.sv
// One stage of the elastic pipeline: payload register plus valid bit.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   flush                 clear valid on the next edge (data holds)
//   accept                this stage can take a beat this cycle
//   emit                  the downstream side takes this stage's beat this cycle
//   src_valid, src_data   beat offered by the upstream side
//   valid, data           registered stage contents
//   valid_next            next-state valid, used by the top for the occupancy count
module elastic_stage #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             accept,
    input  logic             emit,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic             valid_next,
    output logic [WIDTH-1:0] data
);

    logic take;

    always_comb begin
        take       = accept & src_valid;
        valid_next = valid;
        if (flush) begin
            valid_next = 1'b0;
        end else if (take) begin
            valid_next = 1'b1;
        end else if (emit) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else begin
            valid <= valid_next;
            if (take) begin
                data <= src_data;
            end
        end
    end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Multi-stage elastic pipeline register with valid/ready handshake, global
// enable (freeze), synchronous flush and a registered occupancy count.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   en                    0 freezes every stage (no accept, no emit)
//   flush                 clears all valid bits on the next edge; wins over everything
//   in_valid/in_data      upstream beat, in_ready returned
//   out_valid/out_data    beat in the last stage, out_ready from downstream
//   occupancy             registered count of valid stages
module elastic_pipe_reg
    import elastic_pipe_reg_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          out_ready,
    output logic [occ_width(DEPTH)-1:0]   occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]            valid;
    logic [DEPTH-1:0]            valid_next;
    logic [DEPTH-1:0][WIDTH-1:0] data;
    logic [DEPTH-1:0]            stage_ready;
    logic [DEPTH-1:0]            emit;
    logic                        go;
    logic [OCC_W-1:0]            occ_next;

    // Reset is folded in so in_ready stays low while reset is held.
    assign go = en & ~flush & ~reset;

    // Ready chain walks from the output side back to stage 0.
    always_comb begin
        logic nxt;
        nxt         = out_ready & go;
        emit        = '0;
        stage_ready = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            emit[i]        = nxt;
            stage_ready[i] = go & (~valid[i] | nxt);
            nxt            = stage_ready[i];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;

        if (i == 0) begin : g_first
            assign src_valid = in_valid;
            assign src_data  = in_data;
        end else begin : g_chain
            assign src_valid = valid[i-1];
            assign src_data  = data[i-1];
        end

        elastic_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .accept     (stage_ready[i]),
            .emit       (emit[i]),
            .src_valid  (src_valid),
            .src_data   (src_data),
            .valid      (valid[i]),
            .valid_next (valid_next[i]),
            .data       (data[i])
        );
    end

    assign in_ready  = stage_ready[0];
    assign out_valid = valid[DEPTH-1] & en & ~flush;
    assign out_data  = data[DEPTH-1];

    always_comb begin
        occ_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_next = occ_next + OCC_W'(valid_next[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_next;
        end
    end

endmodule
